// File: rtl/sram_req_server_pkg.sv
// Shared command encodings and arbitration state for the ZBT SRAM request server.
package sram_req_server_pkg;

    localparam logic [3:0] WE_WRITE = 4'b0000;
    localparam logic [3:0] WE_IDLE  = 4'b1111;

    typedef enum logic {
        PRIO_RD,
        PRIO_WR
    } prio_e;

endpackage

// File: rtl/sram_req_server_arbiter.sv
// Two-port round-robin arbiter; a port granted in one cycle is masked for the next
// because its requester still holds req for one cycle after the ack.
module sram_req_arbiter
    import sram_req_server_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic rd_req,
    input  logic wr_req,
    output logic grant_rd,
    output logic grant_wr
);

    prio_e prio;
    logic  hold_rd;
    logic  hold_wr;
    logic  rd_elig;
    logic  wr_elig;

    always_comb begin
        rd_elig  = rd_req & ~hold_rd;
        wr_elig  = wr_req & ~hold_wr;
        grant_rd = ~reset & rd_elig & (~wr_elig | (prio == PRIO_RD));
        grant_wr = ~reset & wr_elig & ~grant_rd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio    <= PRIO_RD;
            hold_rd <= 1'b0;
            hold_wr <= 1'b0;
        end else begin
            hold_rd <= grant_rd;
            hold_wr <= grant_wr;
            if (grant_rd) begin
                prio <= PRIO_WR;
            end else if (grant_wr) begin
                prio <= PRIO_RD;
            end
        end
    end

endmodule

// File: rtl/sram_req_server.sv
// Serves one read or write port per cycle onto a ZBT SRAM, with the 2-cycle
// write-data and 3-cycle read-valid pipelines aligned to the device latency.
module sram_req_server
    import sram_req_server_pkg::*;
#(
    parameter int SRAM_ADDR_WIDTH = 19,
    parameter int SRAM_DATA_WIDTH = 36
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_req,
    input  logic [SRAM_ADDR_WIDTH-1:0] wr_addr,
    input  logic [SRAM_DATA_WIDTH-1:0] wr_data,
    output logic                       wr_ack,
    input  logic                       rd_req,
    input  logic [SRAM_ADDR_WIDTH-1:0] rd_addr,
    output logic                       rd_ack,
    output logic                       rd_vld,
    output logic [SRAM_DATA_WIDTH-1:0] rd_data,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic [3:0]                 sram_we_bw,
    output logic [SRAM_DATA_WIDTH-1:0] sram_wr_data,
    input  logic [SRAM_DATA_WIDTH-1:0] sram_rd_data,
    output logic                       sram_tri_en
);

    logic                       grant_rd;
    logic                       grant_wr;
    logic [SRAM_ADDR_WIDTH-1:0] addr_q;
    logic [SRAM_DATA_WIDTH-1:0] wr_data_p1;
    logic                       wr_vld_p1;
    logic                       rd_vld_p1;
    logic                       rd_vld_p2;

    sram_req_arbiter u_arbiter (
        .clk      (clk),
        .reset    (reset),
        .rd_req   (rd_req),
        .wr_req   (wr_req),
        .grant_rd (grant_rd),
        .grant_wr (grant_wr)
    );

    // Command and ack are presented in the grant cycle; idle cycles hold the last address.
    always_comb begin
        wr_ack     = grant_wr;
        rd_ack     = grant_rd;
        sram_we_bw = grant_wr ? WE_WRITE : WE_IDLE;
        if (grant_wr) begin
            sram_addr = wr_addr;
        end else if (grant_rd) begin
            sram_addr = rd_addr;
        end else begin
            sram_addr = addr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q       <= '0;
            wr_data_p1   <= '0;
            wr_vld_p1    <= 1'b0;
            sram_wr_data <= '0;
            sram_tri_en  <= 1'b0;
            rd_vld_p1    <= 1'b0;
            rd_vld_p2    <= 1'b0;
            rd_vld       <= 1'b0;
            rd_data      <= '0;
        end else begin
            addr_q       <= sram_addr;
            wr_vld_p1    <= grant_wr;
            sram_tri_en  <= wr_vld_p1;
            sram_wr_data <= wr_data_p1;
            if (grant_wr) begin
                wr_data_p1 <= wr_data;
            end
            rd_vld_p1 <= grant_rd;
            rd_vld_p2 <= rd_vld_p1;
            rd_vld    <= rd_vld_p2;
            if (rd_vld_p2) begin
                rd_data <= sram_rd_data;
            end
        end
    end

endmodule

// File: doc/sram_req_server.md
SRAM_REQ_SERVER -- requirements
Module: sram_req_server

Interface
REQ-001 Parameter SRAM_ADDR_WIDTH, default 19, SRAM word address width.
REQ-002 Parameter SRAM_DATA_WIDTH, default 36, SRAM word width.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 wr_req  input  1  write request; held by requester until wr_ack.
REQ-006 wr_addr  input  SRAM_ADDR_WIDTH  write word address.
REQ-007 wr_data  input  SRAM_DATA_WIDTH  write data.
REQ-008 wr_ack  output  1  one-cycle pulse: write accepted.
REQ-009 rd_req  input  1  read request; held until rd_ack.
REQ-010 rd_addr  input  SRAM_ADDR_WIDTH  read word address.
REQ-011 rd_ack  output  1  one-cycle pulse: read accepted.
REQ-012 rd_vld  output  1  one-cycle pulse: rd_data valid.
REQ-013 rd_data  output  SRAM_DATA_WIDTH  read result; held between pulses.
REQ-014 sram_addr  output  SRAM_ADDR_WIDTH  ZBT SRAM address.
REQ-015 sram_we_bw  output  4  active-low byte-write enables; all 0 = write, all 1 = read/idle.
REQ-016 sram_wr_data  output  SRAM_DATA_WIDTH  data driven to the SRAM pads.
REQ-017 sram_rd_data  input  SRAM_DATA_WIDTH  data returned from the SRAM pads.
REQ-018 sram_tri_en  output  1  1 = drive sram_wr_data onto the pads.

Function
REQ-019 One SRAM command (read or write) is issued per cycle at most; the command cycle is T.
REQ-020 A command is issued in cycle T only if its req is high and that port is not in holdoff; the matching ack is asserted in the same cycle T.
REQ-021 Holdoff: the port acked in cycle T ignores its req in T+1, because requesters drop req one cycle after ack; in T+2 it is eligible again.
REQ-022 Arbitration with both ports eligible: the port not served last wins; the initial priority after reset is read.
REQ-023 Write at T: sram_addr=wr_addr and sram_we_bw=4'b0000 in T; wr_data is registered at T and driven on sram_wr_data with sram_tri_en=1 in T+2 only.
REQ-024 Read at T: sram_addr=rd_addr and sram_we_bw=4'b1111 in T; sram_rd_data is sampled at the end of T+2; rd_data updates and rd_vld=1 in T+3.
REQ-025 Reads and writes may be issued back-to-back in any order with no turnaround bubble; the 2-cycle write-data pipeline and the 3-cycle read-valid pipeline run independently.
REQ-026 Read-after-write to the same address in consecutive commands returns the new data (ZBT device semantics); no forwarding in the block.
REQ-027 Idle cycle: sram_we_bw=4'b1111, sram_addr holds its last value, no ack.
REQ-028 wr_ack and rd_ack are never high in the same cycle; rd_vld count equals rd_ack count, in order.

Reset
REQ-029 While reset is high: wr_ack=0, rd_ack=0, rd_vld=0, rd_data=0, sram_we_bw=4'b1111, sram_tri_en=0, sram_addr=0, sram_wr_data=0, holdoff cleared, priority set to read.
REQ-030 Reset mid-operation flushes both pipelines: no rd_vld and no sram_tri_en are produced for commands issued before reset.

Structure
REQ-031 The 2-stage write pipeline and 3-stage read pipeline are shift registers in this module; the SRAM command encodings (WE all-0, all-1) are localparams.
REQ-032 One sub-module, sram_req_arbiter: two-port round-robin arbiter with holdoff, which outputs grant_rd and grant_wr.

Verification
REQ-033 Single write 0x12345 <- 36'h9_ABCD_EF01 at T -> wr_ack at T, we_bw=0000 at T, tri_en=1 with that data at T+2.
REQ-034 Single read of 0x12345 with the model returning 36'h9_ABCD_EF01 -> rd_ack at T, rd_vld at T+3 with rd_data=36'h9_ABCD_EF01.
REQ-035 wr_req and rd_req held continuously -> grants alternate R,W,R,W; each port at most once per 2 cycles; no double ack.
REQ-036 Requester drops req one cycle after ack (register-access style read-modify-write) -> exactly one command per request; holdoff cycle shows no duplicate.
REQ-037 Reset asserted at T+1 after a read -> no rd_vld at T+3; all outputs at their reset values.
REQ-038 Random mix of 1000 requests against a ZBT SRAM model -> scoreboard matches all read data; rd_vld count equals rd_ack count.
